// File: rtl/tff_toggle_arbiter.sv
// -----------------------------------------------------------------------------
// tff_toggle_arbiter
//
// Round-robin arbiter in front of a bank of toggle flip-flops. Each cycle, one
// requester is chosen by a rotating priority pointer. The chosen requester's
// mask is applied as the T inputs of the bank (q ^= mask). The module also
// keeps a saturating count of the grants it has issued.
//
// Ports:
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset (clears gnt, q, gnt_cnt, pointer)
//   req      [NREQ]        level request per requester, held until granted
//   mask     [NREQ*WIDTH]  toggle masks; requester i owns [i*WIDTH +: WIDTH]
//   clr      synchronous clear of bank and counter; suppresses the grant
//   gnt      [NREQ]        registered one-hot grant pulse
//   q        [WIDTH]       registered TFF bank state
//   gnt_cnt  [16]          registered saturating grant count
// -----------------------------------------------------------------------------
module tff_toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mask,
    input  logic                  clr,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [15:0]           gnt_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [15:0]      cnt_reg, cnt_next;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [WIDTH-1:0] win_mask;
    int               cand;

    // Split the packed mask bus into one word per requester.
    logic [WIDTH-1:0] mask_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask_split
            assign mask_arr[gi] = mask[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search requesters starting at the pointer and wrapping past NREQ-1;
    // the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_reg) + k) % NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    assign win_mask = mask_arr[win_idx];

    always_comb begin
        gnt_next = '0;
        q_next   = q_reg;
        cnt_next = cnt_reg;
        ptr_next = ptr_reg;
        if (clr) begin
            // Clear wins over arbitration; the pointer is kept, so pending
            // requests resume from the same priority position.
            q_next   = '0;
            cnt_next = '0;
        end else if (win_found) begin
            gnt_next[win_idx] = 1'b1;
            q_next            = q_reg ^ win_mask;
            ptr_next          = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            if (cnt_reg != 16'hFFFF) begin
                cnt_next = cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_reg <= '0;
            gnt_reg <= '0;
            q_reg   <= '0;
            cnt_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            gnt_reg <= gnt_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_next;
        end
    end

    assign gnt     = gnt_reg;
    assign q       = q_reg;
    assign gnt_cnt = cnt_reg;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for tff_toggle_arbiter (NREQ=4, WIDTH=8).
// -----------------------------------------------------------------------------
module tb_tff_toggle_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] mask;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [15:0] gnt_cnt;

    int vec_cnt;
    int err_cnt;

    tff_toggle_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .mask    (mask),
        .clr     (clr),
        .gnt     (gnt),
        .q       (q),
        .gnt_cnt (gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_masks(input logic [7:0] m0, input logic [7:0] m1,
                             input logic [7:0] m2, input logic [7:0] m3);
        mask = {m3, m2, m1, m0};
    endtask

    // Reset pulse that restores ptr=0; leaves inputs idle.
    task automatic do_reset();
        req  = 4'b0000;
        clr  = 1'b0;
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req  = 4'b0000;
        clr  = 1'b0;
        mask = '0;
        rstn = 1'b0;
        #12;
        vec_cnt++;
        if (gnt !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_gnt: got %b expected 0000", gnt);
        end
        vec_cnt++;
        if (q !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_q: got %h expected 00", q);
        end
        vec_cnt++;
        if (gnt_cnt !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_cnt: got %h expected 0000", gnt_cnt);
        end
        $display("reset: gnt=%b q=%h cnt=%h", gnt, q, gnt_cnt);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h0F;
        exp_q[1] = 8'h00;
        exp_q[2] = 8'h0F;
        set_masks(8'h0F, 8'h00, 8'h00, 8'h00);
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if (gnt !== 4'b0001) begin
                err_cnt++;
                $display("FAIL single_gnt[%0d]: got %b expected 0001", i, gnt);
            end
            vec_cnt++;
            if (q !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL single_q[%0d]: got %h expected %h", i, q, exp_q[i]);
            end
            $display("single[%0d]: gnt=%b q=%h", i, gnt, q);
        end
        req = 4'b0000;
        vec_cnt++;
        if (gnt_cnt !== 16'd3) begin
            err_cnt++;
            $display("FAIL single_cnt: got %0d expected 3", gnt_cnt);
        end
        tick();
        vec_cnt++;
        if (gnt !== 4'b0000 || q !== 8'h0F || gnt_cnt !== 16'd3) begin
            err_cnt++;
            $display("FAIL idle_hold: got gnt=%b q=%h cnt=%0d expected 0000/0f/3",
                     gnt, q, gnt_cnt);
        end
        $display("idle: gnt=%b q=%h cnt=%0d", gnt, q, gnt_cnt);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [6];
        logic [7:0] exp_q [6];
        exp_g[0] = 4'b0001; exp_q[0] = 8'h01;
        exp_g[1] = 4'b0010; exp_q[1] = 8'h03;
        exp_g[2] = 4'b0100; exp_q[2] = 8'h07;
        exp_g[3] = 4'b1000; exp_q[3] = 8'h0F;
        exp_g[4] = 4'b0001; exp_q[4] = 8'h0E;
        exp_g[5] = 4'b0010; exp_q[5] = 8'h0C;
        do_reset();
        set_masks(8'h01, 8'h02, 8'h04, 8'h08);
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            vec_cnt++;
            if (gnt !== exp_g[i] || q !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL rr[%0d]: got gnt=%b q=%h expected gnt=%b q=%h",
                         i, gnt, q, exp_g[i], exp_q[i]);
            end
            $display("rr[%0d]: gnt=%b q=%h", i, gnt, q);
        end
        vec_cnt++;
        if (gnt_cnt !== 16'd6) begin
            err_cnt++;
            $display("FAIL rr_cnt: got %0d expected 6", gnt_cnt);
        end
    endtask

    // Continues from round robin: ptr=2, q=0x0C, masks 01/02/04/08.
    task automatic test_pointer_wrap();
        req = 4'b0100;
        tick();
        vec_cnt++;
        if (gnt !== 4'b0100 || q !== 8'h08) begin
            err_cnt++;
            $display("FAIL wrap_pre: got gnt=%b q=%h expected 0100/08", gnt, q);
        end
        $display("wrap pre: gnt=%b q=%h", gnt, q);
        req = 4'b0101;
        tick();
        vec_cnt++;
        if (gnt !== 4'b0001 || q !== 8'h09) begin
            err_cnt++;
            $display("FAIL wrap_first: got gnt=%b q=%h expected 0001/09", gnt, q);
        end
        $display("wrap first: gnt=%b q=%h", gnt, q);
        tick();
        vec_cnt++;
        if (gnt !== 4'b0100 || q !== 8'h0D) begin
            err_cnt++;
            $display("FAIL wrap_second: got gnt=%b q=%h expected 0100/0d", gnt, q);
        end
        $display("wrap second: gnt=%b q=%h", gnt, q);
        req = 4'b0000;
    endtask

    task automatic test_clear();
        // Zero the bank, then load 0x5A through requester 0.
        req = 4'b0000;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_masks(8'h5A, 8'h33, 8'h00, 8'h00);
        req = 4'b0001;
        tick();
        vec_cnt++;
        if (q !== 8'h5A || gnt_cnt !== 16'd1) begin
            err_cnt++;
            $display("FAIL clr_setup: got q=%h cnt=%0d expected 5a/1", q, gnt_cnt);
        end
        req = 4'b0010;
        clr = 1'b1;
        tick();
        vec_cnt++;
        if (q !== 8'h00 || gnt !== 4'b0000 || gnt_cnt !== 16'd0) begin
            err_cnt++;
            $display("FAIL clr_wins: got q=%h gnt=%b cnt=%0d expected 00/0000/0",
                     q, gnt, gnt_cnt);
        end
        $display("clr: q=%h gnt=%b cnt=%0d", q, gnt, gnt_cnt);
        clr = 1'b0;
        tick();
        vec_cnt++;
        if (q !== 8'h33 || gnt !== 4'b0010 || gnt_cnt !== 16'd1) begin
            err_cnt++;
            $display("FAIL clr_resume: got q=%h gnt=%b cnt=%0d expected 33/0010/1",
                     q, gnt, gnt_cnt);
        end
        $display("after clr: q=%h gnt=%b cnt=%0d", q, gnt, gnt_cnt);
        req = 4'b0000;
    endtask

    // Builds q=0x3C, cnt=5, gnt=0010, then resets between edges.
    task automatic test_async_reset();
        req = 4'b0000;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_masks(8'h3C, 8'h00, 8'h3C, 8'h81);
        req = 4'b0100;
        tick();
        req = 4'b0011;
        for (int i = 0; i < 4; i++) tick();
        vec_cnt++;
        if (q !== 8'h3C || gnt !== 4'b0010 || gnt_cnt !== 16'd5) begin
            err_cnt++;
            $display("FAIL arst_setup: got q=%h gnt=%b cnt=%0d expected 3c/0010/5",
                     q, gnt, gnt_cnt);
        end
        req  = 4'b0000;
        rstn = 1'b0;
        #2;
        vec_cnt++;
        if (q !== 8'h00 || gnt !== 4'b0000 || gnt_cnt !== 16'd0) begin
            err_cnt++;
            $display("FAIL arst_now: got q=%h gnt=%b cnt=%0d expected 00/0000/0",
                     q, gnt, gnt_cnt);
        end
        $display("async reset: q=%h gnt=%b cnt=%0d", q, gnt, gnt_cnt);
        #1;
        rstn = 1'b1;
        req  = 4'b1000;
        tick();
        vec_cnt++;
        if (gnt !== 4'b1000 || q !== 8'h81 || gnt_cnt !== 16'd1) begin
            err_cnt++;
            $display("FAIL arst_release: got gnt=%b q=%h cnt=%0d expected 1000/81/1",
                     gnt, q, gnt_cnt);
        end
        $display("after release: gnt=%b q=%h cnt=%0d", gnt, q, gnt_cnt);
        req = 4'b0000;
    endtask

    task automatic test_saturation();
        int         shown;
        logic [15:0] exp_cnt;
        shown = 0;
        req = 4'b0000;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_masks(8'h00, 8'hFF, 8'hFF, 8'hFF);
        req = 4'b0001;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            exp_cnt = (i >= 65535) ? 16'hFFFF : 16'(i);
            vec_cnt++;
            if (q !== 8'h00 || gnt !== 4'b0001 || gnt_cnt !== exp_cnt) begin
                err_cnt++;
                if (shown < 5) begin
                    shown++;
                    $display("FAIL sat[%0d]: got q=%h gnt=%b cnt=%h expected 00/0001/%h",
                             i, q, gnt, gnt_cnt, exp_cnt);
                end
            end
        end
        $display("saturation: q=%h gnt=%b cnt=%h", q, gnt, gnt_cnt);
        req = 4'b0000;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_clear();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/tff_toggle_arbiter.md
# tff_toggle_arbiter

Round-robin arbiter that shares one bank of toggle flip-flops among several requesters. Each requester presents a toggle mask and raises a request. The arbiter grants one requester per cycle and applies that requester's mask as the T inputs of the bank, so q ^= mask. It sits between the requesting control logic and the TFF bank that it owns, and it exports the bank state and a grant counter.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 8: number of toggle flip-flops in the bank
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- req  in  NREQ  request per requester; level, held until granted
- mask  in  NREQ*WIDTH  toggle mask; requester i owns bits [i*WIDTH +: WIDTH]
- clr  in  1  synchronous clear of bank and counter; overrides arbitration
- gnt  out  NREQ  registered one-hot grant, high for one cycle per grant
- q  out  WIDTH  registered TFF bank state
- gnt_cnt  out  16  registered count of grants issued, saturating

## Operation
- Reset (rstn=0, asynchronous) sets gnt=0, q=0, gnt_cnt=0 and the priority pointer ptr=0. All take effect immediately, regardless of clk.
- Each cycle with clr=0 and req!=0:
  - the winner w is the first set bit of req searched from ptr upward, wrapping NREQ-1 to 0;
  - at the clock edge: gnt <= onehot(w), q <= q ^ mask[w], ptr <= (w+1) mod NREQ, and gnt_cnt increments unless it is already 0xFFFF.
- A cycle with req=0 sets gnt <= 0 and leaves q, ptr and gnt_cnt unchanged.
- A cycle with clr=1 sets q <= 0, gnt_cnt <= 0 and gnt <= 0, and issues no grant. ptr is unchanged. Pending requests remain and are arbitrated in the first cycle with clr=0.
- A zero mask still wins arbitration. It is granted and counted, and q is unchanged.
- One grant applies exactly one toggle. There is no partial or merged application of multiple masks.
- Requester handshake:
  - Keep req high, with a stable mask, until gnt[i] is seen.
  - A req still high in the cycle gnt[i] is asserted counts as a new request. It is eligible again, at lowest priority because ptr has moved past i.
- Fairness: with all NREQ requesting continuously, each requester receives exactly one grant in every NREQ consecutive cycles. A lone continuous requester is granted every cycle.
- ptr advances only on a grant.
- Saturation: gnt_cnt holds at 0xFFFF and never wraps to 0. Only clr or rstn clear it.

## Timing
- req and mask are sampled in cycle N. The gnt pulse and the updated q are both visible in cycle N+1, so grant-to-toggle latency is 0 relative to gnt and 1 cycle relative to req.
- gnt_cnt updates on the same edge as gnt.
- Outputs are purely registered, with no combinational path from req, mask or clr to any output.
- Back-to-back grants are allowed every cycle. There is no dead cycle between grants to different requesters.
- clr and req in the same cycle: clr wins and gnt stays 0 next cycle.
- If rstn is asserted mid-pulse, gnt drops to 0 immediately. After rstn deasserts, the first edge arbitrates from ptr=0.

## Test plan
All cases use NREQ=4 and WIDTH=8.

- **Async reset:** with q=0x3C, gnt_cnt=5 and gnt=0010, drop rstn between edges -> q=0x00, gnt=0000 and gnt_cnt=0 immediately, with no clock edge needed. Release rstn, then req=1000 -> gnt=1000 one cycle later.
- **Single requester:** req=0001, mask0=0x0F, held 3 cycles from reset -> gnt=0001 for 3 cycles, q sequence 0x0F, 0x00, 0x0F, then gnt_cnt=3.
- **Round robin:** req=1111 continuous, masks 0x01/0x02/0x04/0x08 -> grant order 0,1,2,3,0,1 and q sequence 0x01, 0x03, 0x07, 0x0F, 0x0E, 0x0C.
- **Pointer wrap:** after a grant to requester 2, present req=0101 -> grant 0 first (search 3,0), then 2. Pointer wrap is checked; no requester is skipped.
- **Clear vs request:** with q=0x5A, req=0010 and clr=1 for one cycle -> q=0x00, gnt=0000, gnt_cnt=0. Then clr=0 -> gnt=0010 and q=mask1 one cycle later.
- **Saturation and zero mask:** continuous req=0001 with mask0=0x00 for 70000 cycles -> q stays 0x00 and gnt_cnt reaches and holds 0xFFFF.
